// File: rtl/accum_window_sampler.sv
// accum_window_sampler: splits the accumulator's running sum into windows of
// WINDOW enabled samples and reports the per-window modular sum increase and
// wrap count on a one-entry valid/ready output register. If a record arrives
// while the previous one is still unaccepted, the new record is lost and a
// sticky dropped flag is raised.
module accum_window_sampler #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned WINDOW = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] acc_in,
  input  logic             acc_en,
  output logic [WIDTH-1:0] delta_out,
  output logic [CNT_W-1:0] wraps_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             dropped
);

  localparam int unsigned CNT_BITS = $clog2(WINDOW);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(WINDOW - 1);
  localparam logic [CNT_W-1:0]    WRAP_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_base;
  logic [WIDTH-1:0]    r_prev;
  logic [CNT_BITS-1:0] r_cnt;
  logic [CNT_W-1:0]    r_wraps;

  logic [WIDTH-1:0]    w_base_nxt;
  logic [WIDTH-1:0]    w_prev_nxt;
  logic [CNT_BITS-1:0] w_cnt_nxt;
  logic [CNT_W-1:0]    w_wraps_nxt;
  logic [CNT_W-1:0]    w_wraps_sat;
  logic                w_wrap;
  logic                w_close;

  logic [WIDTH-1:0]    w_delta_nxt;
  logic [CNT_W-1:0]    w_wraps_out_nxt;
  logic                w_valid_nxt;
  logic                w_dropped_nxt;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Window tracking next-state and output-register next values.
  always_comb begin
    w_state_nxt     = r_state;
    w_base_nxt      = r_base;
    w_prev_nxt      = r_prev;
    w_cnt_nxt       = r_cnt;
    w_wraps_nxt     = r_wraps;
    w_close         = 1'b0;
    w_delta_nxt     = delta_out;
    w_wraps_out_nxt = wraps_out;
    w_valid_nxt     = out_valid;
    w_dropped_nxt   = dropped;

    // A drop in the running sum means it wrapped once since the last sample.
    w_wrap      = (acc_in < r_prev);
    w_wraps_sat = (w_wrap && (r_wraps != WRAP_MAX)) ? r_wraps + CNT_W'(1) : r_wraps;

    case (r_state)
      IDLE: begin
        if (acc_en) begin
          w_base_nxt  = acc_in;
          w_prev_nxt  = acc_in;
          w_cnt_nxt   = '0;
          w_wraps_nxt = '0;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (acc_en) begin
          w_prev_nxt = acc_in;
          if (r_cnt == CNT_LAST) begin
            // Closing sample also becomes the base of the next window.
            w_close     = 1'b1;
            w_base_nxt  = acc_in;
            w_cnt_nxt   = '0;
            w_wraps_nxt = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_BITS'(1);
            w_wraps_nxt = w_wraps_sat;
          end
        end
      end
    endcase

    // Accepted record leaves; a fresh close may refill on the same edge.
    if (out_valid && out_ready) begin
      w_valid_nxt = 1'b0;
    end
    if (w_close) begin
      if (!out_valid || out_ready) begin
        w_valid_nxt     = 1'b1;
        w_delta_nxt     = acc_in - r_base;
        w_wraps_out_nxt = w_wraps_sat;
      end else begin
        w_dropped_nxt   = 1'b1;
      end
    end
  end

  // Window datapath registers and output record register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_base    <= '0;
      r_prev    <= '0;
      r_cnt     <= '0;
      r_wraps   <= '0;
      delta_out <= '0;
      wraps_out <= '0;
      out_valid <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      r_base    <= w_base_nxt;
      r_prev    <= w_prev_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wraps   <= w_wraps_nxt;
      delta_out <= w_delta_nxt;
      wraps_out <= w_wraps_out_nxt;
      out_valid <= w_valid_nxt;
      dropped   <= w_dropped_nxt;
    end
  end

endmodule

// File: tb/tb_accum_window_sampler.sv
// Directed bench for accum_window_sampler: one instance with WINDOW=4 and one
// with WINDOW=2, driven with hand-computed sample sequences.
module tb_accum_window_sampler;

  logic        clk;
  logic        reset;

  logic [15:0] a_in;
  logic        a_en;
  logic        a_ready;
  logic [15:0] a_delta;
  logic [7:0]  a_wraps;
  logic        a_valid;
  logic        a_dropped;

  logic [15:0] b_in;
  logic        b_en;
  logic        b_ready;
  logic [15:0] b_delta;
  logic [7:0]  b_wraps;
  logic        b_valid;
  logic        b_dropped;

  int n_checks = 0;
  int n_fail   = 0;

  accum_window_sampler #(.WIDTH(16), .WINDOW(4), .CNT_W(8)) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .acc_in    (a_in),
    .acc_en    (a_en),
    .delta_out (a_delta),
    .wraps_out (a_wraps),
    .out_valid (a_valid),
    .out_ready (a_ready),
    .dropped   (a_dropped)
  );

  accum_window_sampler #(.WIDTH(16), .WINDOW(2), .CNT_W(8)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .acc_in    (b_in),
    .acc_en    (b_en),
    .delta_out (b_delta),
    .wraps_out (b_wraps),
    .out_valid (b_valid),
    .out_ready (b_ready),
    .dropped   (b_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one sample to instance A, clock it, settle past the edge.
  task automatic step_a(input logic en, input logic [15:0] v);
    a_en = en;
    a_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic en, input logic [15:0] v);
    b_en = en;
    b_in = v;
    @(posedge clk);
    #1;
  endtask

  // Reset both instances and release away from the rising edge.
  task automatic do_reset();
    a_en = 1'b0;
    b_en = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    a_in    = '0;
    a_en    = 1'b0;
    a_ready = 1'b1;
    b_in    = '0;
    b_en    = 1'b0;
    b_ready = 1'b1;

    // Reset state
    @(posedge clk);
    #1;
    check("rst_valid",   32'(a_valid),   0);
    check("rst_delta",   32'(a_delta),   0);
    check("rst_wraps",   32'(a_wraps),   0);
    check("rst_dropped", 32'(a_dropped), 0);
    @(negedge clk);
    reset = 1'b1;

    // Basic window: 0,5,10,15,20 -> delta 20; next window based at 20
    step_a(1'b1, 16'd0);
    step_a(1'b1, 16'd5);
    step_a(1'b1, 16'd10);
    step_a(1'b1, 16'd15);
    check("basic_pre_valid", 32'(a_valid), 0);
    step_a(1'b1, 16'd20);
    check("basic_valid", 32'(a_valid), 1);
    check("basic_delta", 32'(a_delta), 20);
    check("basic_wraps", 32'(a_wraps), 0);
    step_a(1'b1, 16'd25);
    check("basic_xfer_valid", 32'(a_valid), 0);
    step_a(1'b1, 16'd30);
    step_a(1'b1, 16'd35);
    step_a(1'b1, 16'd40);
    check("basic2_valid", 32'(a_valid), 1);
    check("basic2_delta", 32'(a_delta), 20);

    // Wrap: 65530,65535,4,9,14 -> delta 20, one wrap
    do_reset();
    step_a(1'b1, 16'd65530);
    step_a(1'b1, 16'd65535);
    step_a(1'b1, 16'd4);
    step_a(1'b1, 16'd9);
    step_a(1'b1, 16'd14);
    check("wrap_valid", 32'(a_valid), 1);
    check("wrap_delta", 32'(a_delta), 20);
    check("wrap_wraps", 32'(a_wraps), 1);

    // Back-pressure: ten samples of ramp +5 with out_ready=0
    do_reset();
    a_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step_a(1'b1, 16'(i * 5));
      if (i == 4) begin
        check("bp_first_valid",   32'(a_valid),   1);
        check("bp_first_delta",   32'(a_delta),   20);
        check("bp_first_dropped", 32'(a_dropped), 0);
      end
      if (i == 8) begin
        check("bp_drop_dropped", 32'(a_dropped), 1);
        check("bp_drop_delta",   32'(a_delta),   20);
        check("bp_drop_valid",   32'(a_valid),   1);
      end
    end
    check("bp_hold_delta", 32'(a_delta), 20);
    a_ready = 1'b1;
    step_a(1'b0, 16'd0);
    check("bp_xfer_valid", 32'(a_valid), 0);
    step_a(1'b1, 16'd50);
    step_a(1'b1, 16'd55);
    step_a(1'b1, 16'd60);
    check("bp_third_valid",   32'(a_valid),   1);
    check("bp_third_delta",   32'(a_delta),   20);
    check("bp_third_dropped", 32'(a_dropped), 1);

    // Gaps: disabled samples carry junk that must be ignored
    do_reset();
    a_ready = 1'b1;
    step_a(1'b1, 16'd0);
    step_a(1'b1, 16'd5);
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0, 16'hFFFF);
      check("gap_valid", 32'(a_valid), 0);
    end
    step_a(1'b1, 16'd10);
    step_a(1'b1, 16'd15);
    check("gap_pre_valid", 32'(a_valid), 0);
    step_a(1'b1, 16'd20);
    check("gap_valid_close", 32'(a_valid), 1);
    check("gap_delta",       32'(a_delta), 20);
    check("gap_wraps",       32'(a_wraps), 0);

    // WINDOW=2: record every 2 samples, then close coinciding with transfer
    do_reset();
    b_ready = 1'b1;
    step_b(1'b1, 16'd0);
    step_b(1'b1, 16'd5);
    step_b(1'b1, 16'd10);
    check("w2_first_valid", 32'(b_valid), 1);
    check("w2_first_delta", 32'(b_delta), 10);
    step_b(1'b1, 16'd15);
    step_b(1'b1, 16'd20);
    check("w2_second_valid", 32'(b_valid), 1);
    check("w2_second_delta", 32'(b_delta), 10);
    b_ready = 1'b0;
    step_b(1'b1, 16'd25);
    check("w2_hold_valid", 32'(b_valid), 1);
    check("w2_hold_delta", 32'(b_delta), 10);
    b_ready = 1'b1;
    step_b(1'b1, 16'd55);
    check("w2_swap_valid",   32'(b_valid),   1);
    check("w2_swap_delta",   32'(b_delta),   35);
    check("w2_swap_dropped", 32'(b_dropped), 0);

    // Async reset mid-window with a held record and dropped set
    do_reset();
    a_ready = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      step_a(1'b1, 16'(i * 5));
    end
    check("ar_pre_valid",   32'(a_valid),   1);
    check("ar_pre_dropped", 32'(a_dropped), 1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_valid",   32'(a_valid),   0);
    check("ar_delta",   32'(a_delta),   0);
    check("ar_wraps",   32'(a_wraps),   0);
    check("ar_dropped", 32'(a_dropped), 0);
    @(negedge clk);
    reset   = 1'b1;
    a_ready = 1'b1;
    step_a(1'b1, 16'd100);
    step_a(1'b1, 16'd105);
    step_a(1'b1, 16'd110);
    step_a(1'b1, 16'd115);
    check("ar_post_pre_valid", 32'(a_valid), 0);
    step_a(1'b1, 16'd120);
    check("ar_post_valid",   32'(a_valid),   1);
    check("ar_post_delta",   32'(a_delta),   20);
    check("ar_post_wraps",   32'(a_wraps),   0);
    check("ar_post_dropped", 32'(a_dropped), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
